// File: rtl/display_update_ctrl.sv
// Frame-synchronous commit of game-state snapshots into shadow registers during vblank.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module display_update_ctrl #(
`ifdef CURSOR_BLINK_EN
  parameter int BLINK_FRAMES = 30,
`endif
  parameter int V_ACTIVE = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [10:0]  y,
  input  logic         update,
  input  logic         loading,
  input  logic [255:0] boardData_in,
  input  logic [63:0]  moveOptions_in,
  input  logic [5:0]   cursorPosition_in,
  input  logic [5:0]   selectedPosition_in,
  input  logic         turn_in,
  output logic [255:0] boardData,
  output logic [63:0]  moveOptions,
  output logic [5:0]   cursorPosition,
  output logic [5:0]   selectedPosition,
  output logic         turn,
  output logic         busy,
  output logic         update_ack,
  output logic         frame_tick,
  output logic         blank_display,
  output logic         cursor_visible
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [1:0]   state, state_nxt;
  logic         hold_req, hold_req_nxt;
  logic         vblank, vblank_q, commit;

  logic [255:0] stage_board;
  logic [63:0]  stage_moves;
  logic [5:0]   stage_cursor;
  logic [5:0]   stage_selected;
  logic         stage_turn;

  assign vblank = (y >= 11'(V_ACTIVE));

  // Handshake: update is a level request sampled every cycle (latest wins);
  // update_ack pulses once on the edge that commits the staged snapshot.
  assign commit = (state == ST_PENDING) && vblank && !loading && !update;

  always_comb begin
    state_nxt    = state;
    hold_req_nxt = hold_req;
    case (state)
      ST_IDLE: begin
        if (update) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (commit) begin
          state_nxt    = ST_HOLD;
          hold_req_nxt = 1'b0;
        end
      end
      ST_HOLD: begin
        // A request seen in HOLD waits for the next frame's vblank.
        if (update) hold_req_nxt = 1'b1;
        if (!vblank) begin
          state_nxt    = (hold_req || update) ? ST_PENDING : ST_IDLE;
          hold_req_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      hold_req         <= 1'b0;
      vblank_q         <= 1'b0;
      frame_tick       <= 1'b0;
      update_ack       <= 1'b0;
      busy             <= 1'b0;
      blank_display    <= 1'b0;
      stage_board      <= '0;
      stage_moves      <= '0;
      stage_cursor     <= '0;
      stage_selected   <= '0;
      stage_turn       <= 1'b0;
      boardData        <= '0;
      moveOptions      <= '0;
      cursorPosition   <= '0;
      selectedPosition <= '0;
      turn             <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_req      <= hold_req_nxt;
      vblank_q      <= vblank;
      frame_tick    <= vblank && !vblank_q;
      update_ack    <= commit;
      busy          <= (state_nxt == ST_PENDING) || ((state_nxt == ST_HOLD) && hold_req_nxt);
      blank_display <= loading;
      if (update) begin
        stage_board    <= boardData_in;
        stage_moves    <= moveOptions_in;
        stage_cursor   <= cursorPosition_in;
        stage_selected <= selectedPosition_in;
        stage_turn     <= turn_in;
      end
      if (commit) begin
        boardData        <= stage_board;
        moveOptions      <= stage_moves;
        cursorPosition   <= stage_cursor;
        selectedPosition <= stage_selected;
        turn             <= stage_turn;
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] blink_cnt;
  logic          cursor_vis_q;

  // A cursor move restarts the blink phase so the new square is shown at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt    <= '0;
      cursor_vis_q <= 1'b1;
    end else if (commit && (stage_cursor != cursorPosition)) begin
      blink_cnt    <= '0;
      cursor_vis_q <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt    <= '0;
        cursor_vis_q <= !cursor_vis_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign cursor_visible = cursor_vis_q;
`else
  assign cursor_visible = 1'b1;
`endif

endmodule
